seq_stim_gen: RTL and testbench

Registered stimulus generator that sits directly upstream of the start/burst/done protocol checker. A single `go` request produces:

- a one-cycle `start` pulse,
- then a `BURST_LEN`-cycle burst on either lane `a` or lane `b`,
- then, after a programmable gap, a one-cycle `done` pulse.

With default parameters its output satisfies `$rose(start) |=> a[*2] or b[*2]`, so it serves as the DUT-side driver for that check.

---
 rtl/seq_stim_pkg.sv | 30 +++
 rtl/seq_stim_gen.sv | 178 +++++++++++++++++
 tb/tb_seq_stim_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_stim_pkg.sv
// seq_stim_pkg: shared types and constants for the seq_stim_gen stimulus generator.
//   seq_stim_state_t    : FSM state encoding
//   SEQ_STIM_CNT_W      : width of the beat/gap counter
//   SEQ_STIM_BURST_MAX  : largest legal BURST_LEN
//   SEQ_STIM_GAP_MAX    : largest legal DONE_GAP
package seq_stim_pkg;

    localparam int unsigned SEQ_STIM_CNT_W     = 4;
    localparam int unsigned SEQ_STIM_BURST_MAX = 15;
    localparam int unsigned SEQ_STIM_GAP_MAX   = 15;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBurst,
        StGap,
        StDone
    } seq_stim_state_t;

    // Counter reload value for a phase lasting len cycles (len 0 never loads).
    function automatic logic [SEQ_STIM_CNT_W-1:0] seq_stim_last(input int unsigned len);
        logic [SEQ_STIM_CNT_W-1:0] r;
        r = '0;
        if (len > 0) begin
            r = SEQ_STIM_CNT_W'(len - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_stim_gen.sv
// seq_stim_gen: registered start/burst/done stimulus generator.
//
// A go request produces a one-cycle start pulse, then a BURST_LEN-cycle burst on
// lane a (sel=0) or lane b (sel=1), then DONE_GAP idle cycles, then a one-cycle
// done pulse. Requests arriving while busy are dropped (drop pulse one cycle later).
//
// Parameters:
//   BURST_LEN : burst length in cycles, 1..15
//   DONE_GAP  : idle cycles between last burst beat and done, 0..15
// Ports:
//   clk   in  : clock, rising edge
//   rst   in  : synchronous active-high reset
//   go    in  : transaction request
//   sel   in  : lane select, captured with an accepted go
//   start out : one-cycle transaction start pulse
//   a     out : lane A burst
//   b     out : lane B burst
//   done  out : one-cycle completion pulse
//   busy  out : transaction in flight
//   drop  out : one-cycle pulse for a rejected go
//
// Build option:
//   SEQ_STIM_PENDING_EN : adds a one-deep pending request slot; a go while busy with
//                         the slot empty is held and launched straight out of DONE.
module seq_stim_gen
    import seq_stim_pkg::*;
#(
    parameter int unsigned BURST_LEN = 2,
    parameter int unsigned DONE_GAP  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic sel,
    output logic start,
    output logic a,
    output logic b,
    output logic done,
    output logic busy,
    output logic drop
);

    if (BURST_LEN < 1 || BURST_LEN > SEQ_STIM_BURST_MAX) begin : g_bad_burst_len
        $error("seq_stim_gen: BURST_LEN must be in 1..15");
    end
    if (DONE_GAP > SEQ_STIM_GAP_MAX) begin : g_bad_done_gap
        $error("seq_stim_gen: DONE_GAP must be in 0..15");
    end

    localparam logic [SEQ_STIM_CNT_W-1:0] BurstLast = seq_stim_last(BURST_LEN);
    localparam logic [SEQ_STIM_CNT_W-1:0] GapLast   = seq_stim_last(DONE_GAP);
    localparam logic                      HasGap    = (DONE_GAP != 0);

    seq_stim_state_t           state_q, state_d;
    logic [SEQ_STIM_CNT_W-1:0] cnt_q, cnt_d;
    logic                      lane_q, lane_d;
    logic                      drop_d;

`ifdef SEQ_STIM_PENDING_EN
    logic pend_q, pend_d;
    logic pend_sel_q, pend_sel_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        drop_d  = 1'b0;
`ifdef SEQ_STIM_PENDING_EN
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
`endif

        unique case (state_q)
            StIdle: begin
`ifdef SEQ_STIM_PENDING_EN
                // A request parked during the DONE cycle launches from here; a go in the
                // same cycle refills the slot it vacates.
                if (pend_q) begin
                    state_d = StStart;
                    lane_d  = pend_sel_q;
                    pend_d  = go;
                    if (go) begin
                        pend_sel_d = sel;
                    end
                end else
`endif
                if (go) begin
                    state_d = StStart;
                    lane_d  = sel;
                end
            end
            StStart: begin
                state_d = StBurst;
                cnt_d   = BurstLast;
            end
            StBurst: begin
                if (cnt_q == '0) begin
                    if (HasGap) begin
                        state_d = StGap;
                        cnt_d   = GapLast;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef SEQ_STIM_PENDING_EN
                if (pend_q) begin
                    state_d = StStart;
                    lane_d  = pend_sel_q;
                    pend_d  = 1'b0;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        // Requests seen while a transaction is in flight.
        if (go && (state_q != StIdle)) begin
`ifdef SEQ_STIM_PENDING_EN
            // In DONE the slot is either empty or launching this edge, so it can take go.
            if (!pend_q || (state_q == StDone)) begin
                pend_d     = 1'b1;
                pend_sel_d = sel;
            end else begin
                drop_d = 1'b1;
            end
`else
            drop_d = 1'b1;
`endif
        end
    end

    // Outputs are registered from next-state so they align with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lane_q  <= 1'b0;
            start   <= 1'b0;
            a       <= 1'b0;
            b       <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
`ifdef SEQ_STIM_PENDING_EN
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            start   <= (state_d == StStart);
            a       <= (state_d == StBurst) && !lane_d;
            b       <= (state_d == StBurst) && lane_d;
            done    <= (state_d == StDone);
            busy    <= (state_d != StIdle);
            drop    <= drop_d;
`ifdef SEQ_STIM_PENDING_EN
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_stim_gen.sv
// tb_seq_stim_gen: drives two seq_stim_gen instances (defaults, and BURST_LEN=3 /
// DONE_GAP=0) with shared directed and random stimulus and compares every output,
// every cycle, against a transaction-level model: each accepted request is a time
// stamp, and outputs follow from the cycle offset to that stamp.
module tb_seq_stim_gen;

    logic clk = 1'b0;
    logic rst, go, sel;
    logic start0, a0, b0, done0, busy0, drop0;
    logic start1, a1, b1, done1, busy1, drop1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    seq_stim_gen u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .sel   (sel),
        .start (start0),
        .a     (a0),
        .b     (b0),
        .done  (done0),
        .busy  (busy0),
        .drop  (drop0)
    );

    seq_stim_gen #(
        .BURST_LEN (3),
        .DONE_GAP  (0)
    ) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .sel   (sel),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .done  (done1),
        .busy  (busy1),
        .drop  (drop1)
    );

    typedef struct {
        int   t;     // edge at which the current transaction was accepted
        logic vld;   // a transaction has been accepted since reset
        logic lane;
        logic pend;
        logic psel;
        logic drop;
    } mdl_t;

    mdl_t m0, m1;

    // Advance the model across edge n with the inputs sampled there.
    function automatic mdl_t mdl_step(mdl_t m, logic g, logic s, logic r, int n, int bl, int dg);
        mdl_t o = m;
        int   last = bl + 1 + dg;
        logic busy_prev;
        logic done_prev;
        o.drop = 1'b0;
        if (r) begin
            o.vld  = 1'b0;
            o.pend = 1'b0;
            o.psel = 1'b0;
            o.lane = 1'b0;
            return o;
        end
        busy_prev = m.vld && ((n - 1 - m.t) <= last);
        done_prev = m.vld && ((n - 1 - m.t) == last);
        if (!busy_prev) begin
            if (m.pend) begin
                o.vld  = 1'b1;
                o.t    = n;
                o.lane = m.psel;
                o.pend = g;
                if (g) o.psel = s;
            end else if (g) begin
                o.vld  = 1'b1;
                o.t    = n;
                o.lane = s;
            end
        end else begin
            if (m.pend && done_prev) begin
                o.vld  = 1'b1;
                o.t    = n;
                o.lane = m.psel;
                o.pend = 1'b0;
            end
            if (g) begin
`ifdef SEQ_STIM_PENDING_EN
                if (!m.pend || done_prev) begin
                    o.pend = 1'b1;
                    o.psel = s;
                end else begin
                    o.drop = 1'b1;
                end
`else
                o.drop = 1'b1;
`endif
            end
        end
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_dut(input string pfx, input mdl_t m, input int bl, input int dg,
                             input logic st, input logic la, input logic lb,
                             input logic dn, input logic bs, input logic dr);
        int   off  = cyc - m.t;
        int   last = bl + 1 + dg;
        logic on   = m.vld && (off >= 1) && (off <= bl);
        check_eq({pfx, ".start"}, st, m.vld && (off == 0));
        check_eq({pfx, ".a"},     la, on && !m.lane);
        check_eq({pfx, ".b"},     lb, on && m.lane);
        check_eq({pfx, ".done"},  dn, m.vld && (off == last));
        check_eq({pfx, ".busy"},  bs, m.vld && (off >= 0) && (off <= last));
        check_eq({pfx, ".drop"},  dr, m.drop);
    endtask

    // One clock: apply inputs at the falling edge, check one step after the rising edge.
    task automatic step(input logic g, input logic s, input logic r);
        go  = g;
        sel = s;
        rst = r;
        cyc++;
        m0 = mdl_step(m0, g, s, r, cyc, 2, 1);
        m1 = mdl_step(m1, g, s, r, cyc, 3, 0);
        @(posedge clk);
        #1;
        check_dut("d0", m0, 2, 1, start0, a0, b0, done0, busy0, drop0);
        check_dut("d1", m1, 3, 0, start1, a1, b1, done1, busy1, drop1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m0  = '{t: 0, vld: 1'b0, lane: 1'b0, pend: 1'b0, psel: 1'b0, drop: 1'b0};
        m1  = m0;
        go  = 1'b0;
        sel = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Reset state.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // Single request on each lane.
        step(1'b1, 1'b0, 1'b0);
        idle(8);
        step(1'b1, 1'b1, 1'b0);
        idle(8);

        // Second request two cycles after the first.
        step(1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 1'b0);
        idle(14);

        // Third request while the pending slot would be full.
        step(1'b1, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(16);

        // Reset during the burst, then a normal request.
        step(1'b1, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        idle(10);

        // go held high for 20 cycles.
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        idle(10);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 80) == 0));
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
